// File: rtl/seq_div_u.sv
// -----------------------------------------------------------------------------
// seq_div_u : sequential unsigned restoring divider, one radix-2 step per clock.
//
// Recovers an operand from an exact multiplier product (dividend / divisor),
// with valid/ready handshakes on both sides. A divisor of zero short-circuits
// straight to a flagged result (quotient all ones, remainder = dividend).
//
// Parameters
//   WIDTH        operand / result width in bits, 2..32
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   in_valid     dividend/divisor pair presented
//   in_ready     block can accept a pair (IDLE only)
//   dividend     unsigned dividend
//   divisor      unsigned divisor
//   out_valid    result valid (DONE only)
//   out_ready    downstream consumes the result
//   quotient     unsigned quotient
//   remainder    unsigned remainder
//   div_by_zero  result came from divisor == 0
// -----------------------------------------------------------------------------
module seq_div_u #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvs;   // latched divisor
    logic [WIDTH-1:0] q;     // quotient shift register, starts as the dividend
    // The partial remainder is conceptually WIDTH+1 bits, but after every
    // restoring step it is strictly below the divisor, so its top bit is always
    // zero. Only the low WIDTH bits are stored; the extra bit lives in s / t.
    logic [WIDTH-1:0] rem;

    logic [WIDTH:0]   s;
    logic [WIDTH:0]   t;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] q_next;

    // One restoring iteration: shift in the next dividend bit, trial-subtract,
    // keep the difference only if it did not borrow.
    // NOTE: every signal driven here is assigned on every path, so no latch is
    // inferred; combinational blocks use blocking assignments.
    always_comb begin
        s        = {rem, q[WIDTH-1]};
        t        = s - {1'b0, dvs};
        rem_next = t[WIDTH] ? s[WIDTH-1:0] : t[WIDTH-1:0];
        q_next   = {q[WIDTH-2:0], ~t[WIDTH]};
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            dvs         <= '0;
            q           <= '0;
            rem         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            out_valid   <= 1'b0;
            in_ready    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvs      <= divisor;
                        q        <= dividend;
                        rem      <= '0;
                        in_ready <= 1'b0;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            out_valid   <= 1'b1;
                            state       <= DONE;
                        end else begin
                            cnt   <= CW'(WIDTH - 1);
                            state <= RUN;
                        end
                    end
                end

                RUN: begin
                    rem <= rem_next;
                    q   <= q_next;
                    if (cnt == '0) begin
                        // Final step: publish straight from the step results so
                        // the outputs are valid together with out_valid.
                        quotient    <= q_next;
                        remainder   <= rem_next;
                        div_by_zero <= 1'b0;
                        out_valid   <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                DONE: begin
                    // Results hold until consumed; IDLE is re-entered only after
                    // the handshake, so no accept can share this edge.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
